// File: rtl/embeddening_if.sv
// embeddening_if: coefficient-pair stream into the embedder and the saturated result stream out of it.
interface embeddening_if #(parameter int DW = 32);
    logic                 in_valid;
    logic signed [DW-1:0] LL1;
    logic signed [DW-1:0] LL2;
    logic signed [DW-1:0] alpha;
    logic                 out_valid;
    logic signed [DW-1:0] LLNEW;
    logic                 sat_flag;
    modport master(output in_valid, LL1, LL2, alpha, input out_valid, LLNEW, sat_flag);
    modport slave(input in_valid, LL1, LL2, alpha, output out_valid, LLNEW, sat_flag);
endinterface

// File: rtl/embeddening.sv
// embeddening: two-stage additive watermark embedder, LLNEW = sat(LL1 + (LL2*alpha >>> FRAC_BITS)).
module embeddening #(
    parameter int DW        = 32,
    parameter int FRAC_BITS = 0
) (
    input  logic      clk,
    input  logic      rst_n,
    embeddening_if.slave bus
);
    localparam int W = 2*DW + 1;
    logic                  v1_q, v1_d, out_valid_q, out_valid_d, sat_q, sat_d, ovf;
    logic signed [W-1:0]   p1_q, p1_d, scaled, sum;
    logic signed [2*DW-1:0] prod_q, prod_d;
    logic [DW-1:0]         llnew_q, llnew_d;
    always_comb begin
        v1_d        = bus.in_valid;
        p1_d        = bus.in_valid ? {{(DW+1){bus.LL1[DW-1]}}, bus.LL1} : p1_q;
        prod_d      = bus.in_valid ? $signed({{DW{bus.LL2[DW-1]}}, bus.LL2}) * $signed({{DW{bus.alpha[DW-1]}}, bus.alpha}) : prod_q;
        scaled      = $signed({prod_q[2*DW-1], prod_q}) >>> FRAC_BITS;
        sum         = p1_q + scaled;
        // the sum fits DW bits only when every bit above the DW-bit sign matches it
        ovf         = sum[W-1:DW-1] != {(DW+2){sum[W-1]}};
        out_valid_d = v1_q;
        llnew_d     = !v1_q ? llnew_q : ovf ? {sum[W-1], {(DW-1){~sum[W-1]}}} : sum[DW-1:0];
        sat_d       = v1_q ? ovf : sat_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            p1_q        <= '0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
            llnew_q     <= '0;
            sat_q       <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            p1_q        <= p1_d;
            prod_q      <= prod_d;
            out_valid_q <= out_valid_d;
            llnew_q     <= llnew_d;
            sat_q       <= sat_d;
        end
    end
    assign bus.out_valid = out_valid_q;
    assign bus.LLNEW     = llnew_q;
    assign bus.sat_flag  = sat_q;
endmodule

// File: tb/tb_embeddening.sv
// tb_embeddening: drives an integer-alpha and a Q16-alpha embedder with the same stream and checks both.
module tb_embeddening;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    embeddening_if #(.DW(32)) b0();
    embeddening_if #(.DW(32)) b16();
    embeddening #(.DW(32), .FRAC_BITS(0))  u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    embeddening #(.DW(32), .FRAC_BITS(16)) u16(.clk(clk), .rst_n(rst_n), .bus(b16));

    typedef struct {
        bit          v;
        logic [31:0] y0;
        bit          s0;
        logic [31:0] y16;
        bit          s16;
    } exp_t;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    exp_t        p0, p1;
    logic [31:0] ly0 = '0, ly16 = '0;
    bit          ls0 = 1'b0, ls16 = 1'b0;
    int          n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] al,
                                  input int frac, output logic [31:0] y, output bit s);
        longint p, sm;
        p  = longint'($signed(b)) * longint'($signed(al));
        p  = p >>> frac;
        sm = longint'($signed(a)) + p;
        s  = (sm > MAXV) || (sm < MINV);
        y  = sm > MAXV ? 32'h7fffffff : sm < MINV ? 32'h80000000 : sm[31:0];
    endfunction

    task automatic check_outputs(input bit v);
        check("out_valid_f0",  32'(b0.out_valid),  32'(v));
        check("LLNEW_f0",      b0.LLNEW,           ly0);
        check("sat_flag_f0",   32'(b0.sat_flag),   32'(ls0));
        check("out_valid_f16", 32'(b16.out_valid), 32'(v));
        check("LLNEW_f16",     b16.LLNEW,          ly16);
        check("sat_flag_f16",  32'(b16.sat_flag),  32'(ls16));
    endtask

    task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b, input logic [31:0] al,
                        input logic [31:0] y0, input bit s0, input logic [31:0] y16, input bit s16);
        @(negedge clk);
        if (p1.v) begin
            ly0 = p1.y0; ls0 = p1.s0; ly16 = p1.y16; ls16 = p1.s16;
        end
        check_outputs(p1.v);
        p1 = p0;
        p0 = '{v, y0, s0, y16, s16};
        b0.in_valid  = v; b0.LL1  = a; b0.LL2  = b; b0.alpha  = al;
        b16.in_valid = v; b16.LL1 = a; b16.LL2 = b; b16.alpha = al;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    // hand value for the integer-alpha instance, model for the Q16 one
    task automatic d0(input logic [31:0] a, input logic [31:0] b, input logic [31:0] al,
                      input logic [31:0] y, input bit s);
        logic [31:0] y16;
        bit          s16;
        model(a, b, al, 16, y16, s16);
        step(1'b1, a, b, al, y, s, y16, s16);
    endtask

    task automatic d16(input logic [31:0] a, input logic [31:0] b, input logic [31:0] al,
                       input logic [31:0] y, input bit s);
        logic [31:0] y0;
        bit          s0;
        model(a, b, al, 0, y0, s0);
        step(1'b1, a, b, al, y0, s0, y, s);
    endtask

    task automatic clear_expect();
        p0 = '{1'b0, '0, 1'b0, '0, 1'b0};
        p1 = p0;
        ly0 = '0; ly16 = '0; ls0 = 1'b0; ls16 = 1'b0;
    endtask

    initial begin
        clear_expect();
        b0.in_valid  = 1'b0; b0.LL1  = '0; b0.LL2  = '0; b0.alpha  = '0;
        b16.in_valid = 1'b0; b16.LL1 = '0; b16.LL2 = '0; b16.alpha = '0;
        idle(); idle();
        rst_n = 1'b1;
        idle();
        d0(100, 5, 1, 105, 1'b0);
        d0(-20, 7, 1, -13, 1'b0);
        d0(0, 0, 1, 0, 1'b0);
        d0(10, -4, 3, -2, 1'b0);
        idle(); idle();
        d0(50, 25, -2, 0, 1'b0);
        idle();
        d0(1234, 999, 0, 1234, 1'b0);
        d0(-77, 0, 12345, -77, 1'b0);
        d0(32'h7fffffff, 1, 1, 32'h7fffffff, 1'b1);
        d0(32'h80000000, 32'hffffffff, 1, 32'h80000000, 1'b1);
        d0(0, 32'h80000000, 32'h80000000, 32'h7fffffff, 1'b1);
        d0(32'h7ffffffe, 1, 1, 32'h7fffffff, 1'b0);
        d0(32'h80000001, -1, 1, 32'h80000000, 1'b0);
        d16(100, 7, 32'h00008000, 103, 1'b0);
        d16(100, -7, 32'h00008000, 96, 1'b0);
        idle(); idle(); idle();
        d0(1, 1, 1, 2, 1'b0);
        d0(2, 2, 1, 4, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        clear_expect();
        check_outputs(1'b0);
        idle();
        rst_n = 1'b1;
        idle(); idle(); idle();
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] a, b, al, y0, y16;
            bit          v, s0, s16;
            v  = $urandom_range(0, 3) != 0;
            a  = $urandom;
            b  = $urandom_range(0, 1) ? $urandom : 32'($signed($urandom_range(0, 2000)) - 1000);
            al = $urandom_range(0, 1) ? $urandom : 32'($signed($urandom_range(0, 200000)) - 100000);
            model(a, b, al, 0, y0, s0);
            model(a, b, al, 16, y16, s16);
            step(v, a, b, al, y0, s0, y16, s16);
        end
        idle(); idle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
